// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared types and constants for the LIFO read-side engine

package lifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } lifo_state_e;

    localparam int LIFO_DATA_WIDTH = 8;
    localparam int LIFO_SKID_DEPTH = 2;

endpackage

// File: rtl/lifo_skid_buf.sv
// rtl/lifo_skid_buf.sv - two-entry FIFO-ordered valid/ready buffer with occupancy

module lifo_skid_buf
    import lifo_pkg::*;
#(
    parameter int DATA_WIDTH = LIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [1:0]            occ_q;
    logic                  pop;

    assign m_tvalid  = (occ_q != 2'd0);
    assign m_tdata   = head_q;
    assign occupancy = occ_q;
    assign pop       = m_tvalid && m_tready;

    // The head always holds the oldest entry; the tail only fills when the head is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({s_tvalid, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= s_tdata;
                        occ_q  <= 2'd1;
                    end else if (occ_q == 2'd1) begin
                        tail_q <= s_tdata;
                        occ_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= s_tdata;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= s_tdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lifo_reader.sv
// rtl/lifo_reader.sv - LIFO drain engine; LIFO_READER_WAIT_EN makes fixed-length drains wait on empty

module lifo_reader
    import lifo_pkg::*;
#(
    parameter int DATA_WIDTH = LIFO_DATA_WIDTH,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_start,
    input  logic [LEN_WIDTH-1:0]  drain_len,
    output logic                  lifo_read_en,
    input  logic [DATA_WIDTH-1:0] lifo_data_out,
    input  logic                  lifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  done,
    output logic                  short,
    output logic [LEN_WIDTH-1:0]  pop_count
);

    lifo_state_e          state_q;
    lifo_state_e          state_d;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [LEN_WIDTH-1:0] pop_count_q;
    logic                 len0_q;
    logic                 inflight_q;
    logic                 short_q;
    logic                 busy_q;
    logic                 done_q;
    logic [1:0]           occ;
    logic                 out_fire;
    logic [2:0]           pending;
    logic                 exhausted;
    logic                 empty_end;
    logic                 start_ok;
    logic                 flush_done;
    logic                 set_short;

    assign out_fire = m_valid && m_ready;
    // Words already owned by the buffer after this edge, counting the one being returned by the LIFO.
    assign pending  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, out_fire};

    assign lifo_read_en = (state_q == ST_DRAIN) && !lifo_empty
                          && ((remaining_q != '0) || len0_q)
                          && (pending < 3'(LIFO_SKID_DEPTH));

    assign exhausted = !len0_q && (remaining_q == '0);

`ifdef LIFO_READER_WAIT_EN
    assign empty_end = len0_q && lifo_empty;
`else
    assign empty_end = lifo_empty;
`endif

    always_comb begin
        state_d    = state_q;
        start_ok   = 1'b0;
        flush_done = 1'b0;
        set_short  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (drain_start) begin
                    state_d  = ST_DRAIN;
                    start_ok = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (exhausted) begin
                    state_d = ST_FLUSH;
                end else if (empty_end) begin
                    state_d   = ST_FLUSH;
                    set_short = !len0_q;
                end
            end
            ST_FLUSH: begin
                if (!inflight_q && (occ == 2'd0)) begin
                    state_d    = ST_IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            pop_count_q <= '0;
            len0_q      <= 1'b0;
            inflight_q  <= 1'b0;
            short_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= lifo_read_en;
            done_q     <= flush_done;
            if (start_ok) begin
                remaining_q <= drain_len;
                len0_q      <= (drain_len == '0);
                pop_count_q <= '0;
                short_q     <= 1'b0;
                busy_q      <= 1'b1;
            end else if (lifo_read_en) begin
                pop_count_q <= pop_count_q + 1'b1;
                if (!len0_q) begin
                    remaining_q <= remaining_q - 1'b1;
                end
            end
            if (set_short) begin
                short_q <= 1'b1;
            end
            if (flush_done) begin
                busy_q <= 1'b0;
            end
        end
    end

    lifo_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (inflight_q),
        .s_tdata  (lifo_data_out),
        .m_tvalid (m_valid),
        .m_tready (m_ready),
        .m_tdata  (m_data),
        .occupancy(occ)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign short     = short_q;
    assign pop_count = pop_count_q;

endmodule

// File: tb/tb_lifo_reader.sv
// tb/tb_lifo_reader.sv - directed self-checking bench for lifo_reader with a behavioural LIFO

module tb_lifo_reader;

    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          drain_start = 1'b0;
    logic [LW-1:0] drain_len = '0;
    logic          lifo_read_en;
    logic [DW-1:0] lifo_data_out = '0;
    logic          lifo_empty;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;
    logic          drn_short;
    logic [LW-1:0] pop_count;

    lifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .drain_start  (drain_start),
        .drain_len    (drain_len),
        .lifo_read_en (lifo_read_en),
        .lifo_data_out(lifo_data_out),
        .lifo_empty   (lifo_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy),
        .done         (done),
        .short        (drn_short),
        .pop_count    (pop_count)
    );

    always #5 clk = ~clk;

    // Behavioural LIFO: registered data_out, pop wins over push, at most two pushes per edge.
    logic [DW-1:0] stack [0:15];
    int            sp = 0;
    logic          push_en = 1'b0;
    logic          push_two = 1'b0;
    logic [DW-1:0] push_a = '0;
    logic [DW-1:0] push_b = '0;

    always @(posedge clk) begin
        if (lifo_read_en && sp != 0) begin
            lifo_data_out <= stack[sp-1];
            sp <= sp - 1;
        end else if (push_en) begin
            stack[sp] <= push_a;
            if (push_two) stack[sp+1] <= push_b;
            sp <= sp + (push_two ? 2 : 1);
        end
    end
    assign lifo_empty = (sp == 0);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int      got_q[$];
    int      exp_q[$];
    int      cyc;
    int      first_cyc;
    int      done_cnt;
    int      done_cyc;
    int      rd_seen;
    int      stall_bad;
    int      pops;
    int      max_out;
    int      busy_inj;
    logic    held_valid;
    logic [DW-1:0] held_data;

    task automatic push1(input int v);
        push_en  = 1'b1;
        push_two = 1'b0;
        push_a   = DW'(v);
        @(posedge clk);
        #1 push_en = 1'b0;
    endtask

    task automatic load7();
        for (int i = 7; i >= 1; i--) push1(i * 5);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    endtask

    // Starts a drain and observes it cycle by cycle; cyc counts rising edges since the start edge.
    task automatic run_drain(input int len, input bit bp, input int glitch_cyc,
                             input int inject_cyc, input int ia, input int ib);
        got_q.delete();
        first_cyc = -1; done_cnt = 0; done_cyc = -1; rd_seen = 0;
        stall_bad = 0; pops = 0; max_out = 0; busy_inj = -1; held_valid = 1'b0;
        drain_start = 1'b1;
        drain_len   = LW'(len);
        @(posedge clk);
        #1;
        cyc = 0;
        m_ready = bp ? (cyc % 3 == 0) : 1'b1;
        for (int k = 0; k < 120; k++) begin
            drain_start = (cyc == glitch_cyc);
            if (cyc == glitch_cyc) drain_len = LW'(2);
            push_en  = (cyc == inject_cyc);
            push_two = 1'b1;
            push_a   = DW'(ia);
            push_b   = DW'(ib);
            @(negedge clk);
            if (cyc == inject_cyc) busy_inj = int'(busy);
            if (held_valid && m_data !== held_data) stall_bad++;
            if (lifo_read_en) rd_seen++;
            if (lifo_read_en && !lifo_empty) pops++;
            if (m_valid && m_ready) begin
                got_q.push_back(int'(m_data));
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (pops - got_q.size() > max_out) max_out = pops - got_q.size();
            held_valid = m_valid && !m_ready;
            held_data  = m_data;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(posedge clk);
            #1;
            cyc++;
            m_ready = bp ? (cyc % 3 == 0) : 1'b1;
        end
        @(posedge clk);
        #1;
        drain_start = 1'b0;
        push_en     = 1'b0;
        m_ready     = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({lifo_read_en, m_valid, busy, done, drn_short, pop_count, m_data}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full ordered drain
        load7();
        run_drain(7, 1'b0, -1, -1, 0, 0);
        exp_q = '{5, 10, 15, 20, 25, 30, 35};
        check_seq("full");
        check("full_first_valid_cyc", first_cyc, 2);
        check("full_done_cnt", done_cnt, 1);
        check("full_done_cyc", done_cyc, 10);
        check("full_short", int'(drn_short), 0);
        check("full_pop_count", int'(pop_count), 7);
        check("full_busy_after", int'(busy), 0);

        // Back-pressure with m_ready 1,0,0 repeating
        load7();
        run_drain(7, 1'b1, -1, -1, 0, 0);
        check_seq("bp");
        check("bp_stall_changes", stall_bad, 0);
        check("bp_outstanding_le2", int'(max_out <= 2), 1);
        check("bp_done_cnt", done_cnt, 1);
        check("bp_pop_count", int'(pop_count), 7);

        // Short drain: 3 entries, length 5
        push1(10); push1(20); push1(30);
`ifdef LIFO_READER_WAIT_EN
        run_drain(5, 1'b0, -1, 10, 40, 50);
        exp_q = '{30, 20, 10, 50, 40};
        check_seq("wait");
        check("wait_busy_held", busy_inj, 1);
        check("wait_short", int'(drn_short), 0);
        check("wait_pop_count", int'(pop_count), 5);
        check("wait_done_cnt", done_cnt, 1);
`else
        run_drain(5, 1'b0, -1, -1, 0, 0);
        exp_q = '{30, 20, 10};
        check_seq("short");
        check("short_flag", int'(drn_short), 1);
        check("short_pop_count", int'(pop_count), 3);
        check("short_done_cyc", done_cyc, 6);
`endif

        // Len0 on an empty LIFO
        run_drain(0, 1'b0, -1, -1, 0, 0);
        check("len0_read_en_seen", rd_seen, 0);
        check("len0_words", got_q.size(), 0);
        check("len0_done_cyc", done_cyc, 2);
        check("len0_pop_count", int'(pop_count), 0);
        check("len0_short", int'(drn_short), 0);

        // Reset after the third output of a 7-entry drain
        load7();
        got_q.delete();
        drain_start = 1'b1;
        drain_len   = LW'(7);
        m_ready     = 1'b1;
        @(posedge clk);
        #1 drain_start = 1'b0;
        for (int k = 0; k < 40 && got_q.size() < 3; k++) begin
            @(negedge clk);
            if (m_valid && m_ready) got_q.push_back(int'(m_data));
        end
        check("rst_pre_words", got_q.size(), 3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_outputs_cleared", int'({lifo_read_en, m_valid, busy, done, drn_short, pop_count, m_data}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_drain(0, 1'b0, -1, -1, 0, 0);
        exp_q = '{30, 35};
        check_seq("rst_rest");
        check("rst_rest_pop_count", int'(pop_count), 2);
        check("rst_rest_done_cyc", done_cyc, 5);

        // Start pulse while busy is ignored
        load7();
        run_drain(7, 1'b0, 4, -1, 0, 0);
        exp_q = '{5, 10, 15, 20, 25, 30, 35};
        check_seq("ign");
        check("ign_pop_count", int'(pop_count), 7);
        check("ign_done_cnt", done_cnt, 1);
        check("ign_done_cyc", done_cyc, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
